// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file bulk-access sequencer.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;

    localparam logic MODE_DUMP  = 1'b0;
    localparam logic MODE_CLEAR = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        DUMP  = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } seq_state_t;

    // States in which an operation is in flight.
    function automatic logic seq_busy(input seq_state_t s);
        return (s == CLEAR) || (s == DUMP) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/regfile_seq_outreg.sv
// Single-entry valid/ready output register for the dump stream.
module regfile_seq_outreg #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  last_in,
    input  logic                  ready,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last,
    output logic                  free_c
);

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;

    // Slot can take a new beat when empty or when the current beat leaves this cycle.
    assign free_c = !valid_q || ready;

    // Load a new beat, otherwise drop valid on handshake; payload holds while stalled.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = addr_in;
            data_d  = data_in;
            last_d  = last_in;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Beat register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid = valid_q;
    assign addr  = addr_q;
    assign data  = data_q;
    assign last  = last_q;

endmodule

// File: rtl/regfile_port_sequencer.sv
// Bulk CLEAR / DUMP initiator driving the register file write port and one read port.
module regfile_port_sequencer
    import regfile_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned           ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    output logic                  busy,
    output logic                  done,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int unsigned      NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int unsigned      IDX_W    = ADDR_WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    seq_state_t            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    logic                  ob_load_c;
    logic                  ob_last_c;
    logic                  ob_free_c;

    // Read address follows idx only while dumping; IDLE presents x0 so beat 0 can load at accept.
    assign rf_raddr  = (state_q == DUMP) ? idx_q[ADDR_WIDTH-1:0] : '0;
    assign ob_last_c = (state_q == DUMP) && (idx_q == LAST_IDX);

    // Next-state, index and registered-output computation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ob_load_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (mode == MODE_CLEAR) begin
                        state_d = CLEAR;
                        idx_d   = IDX_ONE;
                    end else begin
                        // x0 is captured at the accept edge, so the walk continues from 1.
                        state_d   = DUMP;
                        ob_load_c = ob_free_c;
                        idx_d     = IDX_ONE;
                    end
                end
            end
            CLEAR: begin
                idx_d = idx_q + IDX_ONE;
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                end
            end
            DUMP: begin
                if (ob_free_c) begin
                    ob_load_c = 1'b1;
                    idx_d     = idx_q + IDX_ONE;
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (ob_free_c) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        // Outputs are registered from the state being entered so they line up with it.
        busy_d     = seq_busy(state_d);
        done_d     = (state_d == FIN);
        rf_we_d    = (state_d == CLEAR);
        rf_waddr_d = (state_d == CLEAR) ? idx_d[ADDR_WIDTH-1:0] : '0;
        rf_wdata_d = (state_d == CLEAR) ? CLEAR_VALUE : '0;
    end

    // State, index and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // Dump stream output slot.
    regfile_seq_outreg #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_outreg (
        .clk    (clk),
        .rst    (rst),
        .load   (ob_load_c),
        .addr_in(rf_raddr),
        .data_in(rf_rdata),
        .last_in(ob_last_c),
        .ready  (out_ready),
        .valid  (out_valid),
        .addr   (out_addr),
        .data   (out_data),
        .last   (out_last),
        .free_c (ob_free_c)
    );

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Bench for regfile_port_sequencer with a behavioural 32x32 register file attached.
module tb_regfile_port_sequencer;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic          mode;
    logic          busy;
    logic          done;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;

    // Bench-side preload port into the register file.
    logic          tb_we;
    logic [AW-1:0] tb_waddr;
    logic [DW-1:0] tb_wdata;

    logic [DW-1:0] rf_mem  [NR];
    logic [DW-1:0] exp_mem [NR];

    int checks;
    int errors;

    regfile_port_sequencer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CLEAR_VALUE('0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_data (out_data),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: x0 hardwired zero, writes blocked while the shared reset is high.
    always @(posedge clk) begin
        if (!rst) begin
            if (rf_we) begin
                if (rf_waddr != '0) rf_mem[rf_waddr] <= rf_wdata;
            end else if (tb_we && tb_waddr != '0) begin
                rf_mem[tb_waddr] <= tb_wdata;
            end
        end
    end
    assign rf_rdata = (rf_raddr == '0) ? '0 : rf_mem[rf_raddr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Preload x1..x31 through the bench port; random values unless use_linear.
    task automatic preload(input bit use_linear);
        exp_mem[0] = '0;
        for (int i = 1; i < NR; i++) begin
            tb_we    = 1'b1;
            tb_waddr = AW'(i);
            tb_wdata = use_linear ? DW'(i * 10) : $urandom;
            exp_mem[i] = tb_wdata;
            tick();
        end
        tb_we = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b0;
        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        tick(); tick(); tick();
        checks++;
        if ({busy, done, rf_we, rf_waddr, rf_wdata, rf_raddr, out_valid, out_addr, out_data, out_last} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b we=%b waddr=%0d wdata=%h raddr=%0d ov=%b oa=%0d od=%h ol=%b, required all 0",
                     busy, done, rf_we, rf_waddr, rf_wdata, rf_raddr, out_valid, out_addr, out_data, out_last);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < NR; k++) begin
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== AW'(k) || rf_wdata !== '0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL clear_write[%0d]: we=%b waddr=%0d wdata=%h busy=%b done=%b, required we=1 waddr=%0d wdata=0 busy=1 done=0",
                         k, rf_we, rf_waddr, rf_wdata, busy, done, k);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || rf_we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_done: done=%b we=%b busy=%b, required done=1 we=0 busy=0", done, rf_we, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL clear_done_width: done=%b one cycle later, required 0", done);
        end
        for (int i = 1; i < NR; i++) exp_mem[i] = '0;
        for (int i = 1; i < NR; i++) begin
            checks++;
            if (rf_mem[i] !== exp_mem[i]) begin
                errors++;
                $display("FAIL clear_mem[x%0d]: got %h, required %h", i, rf_mem[i], exp_mem[i]);
            end
        end
    endtask

    // policy: 0 = ready always high, 1 = ready 1,0,0 repeating, 2 = random ready.
    task automatic test_dump(input int policy, input bit poke_start);
        int            n;
        int            last_hs;
        bit            stalled;
        bit            seen_done;
        bit            we_seen;
        bit            busy_bad;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_data;
        logic          h_last;
        n = 0; last_hs = -10; stalled = 0; seen_done = 0; we_seen = 0; busy_bad = 0;
        h_addr = '0; h_data = '0; h_last = 1'b0;
        start = 1'b1; mode = 1'b0; out_ready = 1'b0;
        tick();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_addr !== '0 || out_data !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL dump_first_beat(p%0d): valid=%b addr=%0d data=%h busy=%b, required valid=1 addr=0 data=0 busy=1",
                     policy, out_valid, out_addr, out_data, busy);
        end
        for (int cyc = 1; cyc <= 400 && !seen_done; cyc++) begin
            case (policy)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke_start && cyc == 10) begin
                start = 1'b1; mode = 1'b1;
            end else begin
                start = 1'b0; mode = 1'b0;
            end
            if (rf_we !== 1'b0) we_seen = 1;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_addr !== h_addr || out_data !== h_data || out_last !== h_last) begin
                    errors++;
                    $display("FAIL dump_stall_hold(p%0d) cyc %0d: valid=%b addr=%0d data=%h last=%b, required 1/%0d/%h/%b",
                             policy, cyc, out_valid, out_addr, out_data, out_last, h_addr, h_data, h_last);
                end
            end
            if (done === 1'b1) begin
                seen_done = 1;
                checks++;
                if (n != NR || last_hs != cyc - 1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL dump_done(p%0d): beats=%0d last_hs_cyc=%0d done_cyc=%0d busy=%b, required beats=%0d done one cycle after last beat busy=0",
                             policy, n, last_hs, cyc, busy, NR);
                end
            end else begin
                if (busy !== 1'b1) busy_bad = 1;
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    checks++;
                    if (n >= NR) begin
                        errors++;
                        $display("FAIL dump_extra_beat(p%0d): addr=%0d after %0d beats", policy, out_addr, n);
                    end else if (out_addr !== AW'(n) || out_data !== exp_mem[n] || out_last !== (n == NR - 1)) begin
                        errors++;
                        $display("FAIL dump_beat(p%0d)[%0d]: addr=%0d data=%h last=%b, required addr=%0d data=%h last=%b",
                                 policy, n, out_addr, out_data, out_last, n, exp_mem[n], (n == NR - 1));
                    end
                    n++;
                    last_hs = cyc;
                end
            end
            stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
            h_addr = out_addr; h_data = out_data; h_last = out_last;
            tick();
        end
        start = 1'b0; mode = 1'b0; out_ready = 1'b0;
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL dump_timeout(p%0d): no done within 400 cycles, beats=%0d", policy, n);
        end
        checks++;
        if (we_seen || busy_bad) begin
            errors++;
            $display("FAIL dump_side_effects(p%0d): rf_we_seen=%b busy_dropped=%b, required 0 0", policy, we_seen, busy_bad);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit found;
        bit done_seen;
        found = 0; done_seen = 0;
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (rf_we === 1'b1 && rf_waddr === AW'(12)) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_x12: waddr 12 never seen, got waddr=%0d we=%b", rf_waddr, rf_we);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_edge: we=%b busy=%b done=%b, required 0 0 0", rf_we, busy, done);
        end
        for (int c = 0; c < 6; c++) begin
            if (done === 1'b1 || rf_we === 1'b1) done_seen = 1;
            tick();
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL abort_no_done: done or we seen after abort, required none");
        end
        for (int i = 1; i < 12; i++) exp_mem[i] = '0;
        for (int i = 1; i < NR; i++) begin
            checks++;
            if (rf_mem[i] !== exp_mem[i]) begin
                errors++;
                $display("FAIL abort_mem[x%0d]: got %h, required %h", i, rf_mem[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        seen = 0;
        start = 1'b1; mode = 1'b1;
        tick();
        for (int k = 1; k < NR; k++) begin
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== AW'(k)) begin
                errors++;
                $display("FAIL b2b_write[%0d]: we=%b waddr=%0d, required we=1 waddr=%0d", k, rf_we, rf_waddr, k);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fin: done=%b busy=%b we=%b, required 1 0 0", done, busy, rf_we);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: done=%b busy=%b we=%b, required 0 0 0 (start in FIN must be ignored)", done, busy, rf_we);
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== AW'(1)) begin
            errors++;
            $display("FAIL b2b_second_start: busy=%b we=%b waddr=%0d, required 1 1 1", busy, rf_we, rf_waddr);
        end
        for (int c = 0; c < 40 && !seen; c++) begin
            if (done === 1'b1) seen = 1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_second_done: no done within 40 cycles");
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clear();
        preload(1'b1);
        test_dump(0, 1'b0);
        preload(1'b0);
        test_dump(1, 1'b0);
        preload(1'b0);
        test_dump(2, 1'b1);
        preload(1'b0);
        test_reset_mid_clear();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
